// File: rtl/disp_vramrd_pkg.sv
// Shared state encoding, resolution codes and frame geometry for the display VRAM read engine.
package disp_vramrd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] RESOL_640X480   = 2'd0;
  localparam logic [1:0] RESOL_800X600   = 2'd1;
  localparam logic [1:0] RESOL_1280X1024 = 2'd2;

  localparam int WIDTH_640   = 640;
  localparam int HEIGHT_480  = 480;
  localparam int WIDTH_800   = 800;
  localparam int HEIGHT_600  = 600;
  localparam int WIDTH_1280  = 1280;
  localparam int HEIGHT_1024 = 1024;

  typedef struct packed {
    logic [15:0] bpl;
    logic [15:0] lines;
  } geom_t;

  // Code 3 is reserved and falls back to 640x480.
  function automatic geom_t resol_geom(input logic [1:0] resol, input int data_w,
                                       input int burst_len, input int bpp_bytes);
    geom_t g;
    int    width;
    int    height;
    int    burst_bytes;
    case (resol)
      RESOL_800X600: begin
        width  = WIDTH_800;
        height = HEIGHT_600;
      end
      RESOL_1280X1024: begin
        width  = WIDTH_1280;
        height = HEIGHT_1024;
      end
      default: begin
        width  = WIDTH_640;
        height = HEIGHT_480;
      end
    endcase
    burst_bytes = burst_len * data_w / 8;
    g.bpl       = 16'(width * bpp_bytes / burst_bytes);
    g.lines     = 16'(height);
    return g;
  endfunction

endpackage

// File: rtl/disp_vramrd_sync.sv
// VRSTART two-flop synchroniser plus rising-edge detect.
// o_rise is a one-cycle pulse, combinational from the flops, valid two cycles after the raw edge.
module disp_vramrd_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_sync_d;

endmodule

// File: rtl/disp_vramrd_engine.sv
// Per-frame AXI4 INCR read-burst issuer for the display FIFO; paced by BUF_WREADY, up to MAX_OUTSTANDING in flight.
// Optional DISP_VRAMRD_STRIDE_EN adds a STRIDE input for a programmable line pitch.
module disp_vramrd_engine
  import disp_vramrd_pkg::*;
#(
  parameter int DATA_W          = 64,
  parameter int BURST_LEN       = 16,
  parameter int MAX_OUTSTANDING = 2,
  parameter int BPP_BYTES       = 4
) (
  input  logic        ACLK,
  input  logic        ARST,
  output logic [31:0] ARADDR,
  output logic [7:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  input  logic [1:0]  RESOL,
  input  logic        VRSTART,
  input  logic        DISPON,
  input  logic [28:0] DISPADDR,
`ifdef DISP_VRAMRD_STRIDE_EN
  input  logic [15:0] STRIDE,
`endif
  input  logic        BUF_WREADY,
  output logic        BUSY,
  output logic        FRAME_DONE,
  output logic        VRSTART_OVR
);

  localparam int          BURST_BYTES   = BURST_LEN * DATA_W / 8;
  localparam logic [31:0] BURST_BYTES_W = 32'(BURST_BYTES);
  localparam logic [2:0]  MAX_OUT_W     = 3'(MAX_OUTSTANDING);

  state_t      r_state;
  logic [31:0] r_araddr;
  logic [31:0] r_line_base;
  logic [31:0] r_pitch;
  logic [15:0] r_bpl;
  logic [15:0] r_lines;
  logic [15:0] r_burst;
  logic [15:0] r_line;
  logic [2:0]  r_outstanding;
  logic        r_arvalid;
  logic        r_abort;
  logic        r_frame_done;
  logic        r_ovr;

  logic        w_vr_rise;
  logic        w_ar_hs;
  logic        w_r_done;
  logic        w_rready;
  logic        w_line_end;
  logic        w_frame_end;
  logic [31:0] w_base;
  logic [31:0] w_pitch;
  geom_t       w_geom;
  logic        w_unused;

  disp_vramrd_sync u_sync (
    .i_clk   (ACLK),
    .i_rst   (ARST),
    .i_async (VRSTART),
    .o_rise  (w_vr_rise)
  );

  assign w_geom = resol_geom(RESOL, DATA_W, BURST_LEN, BPP_BYTES);
  assign w_base = {DISPADDR[28:4], 7'd0};

`ifdef DISP_VRAMRD_STRIDE_EN
  assign w_pitch  = {16'd0, STRIDE[15:7], 7'd0};
  assign w_unused = ^{DISPADDR[3:0], STRIDE[6:0]};
`else
  assign w_pitch  = 32'(w_geom.bpl) * BURST_BYTES_W;
  assign w_unused = ^DISPADDR[3:0];
`endif

  assign w_rready    = (r_outstanding != 3'd0);
  assign w_ar_hs     = r_arvalid & ARREADY;
  assign w_r_done    = RVALID & w_rready & RLAST;
  assign w_line_end  = (r_burst == r_bpl - 16'd1);
  assign w_frame_end = w_line_end && (r_line == r_lines - 16'd1);

  // Only RLAST beats retire a burst; simultaneous issue and retire cancel out.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      r_outstanding <= 3'd0;
    end else if (w_ar_hs && !w_r_done) begin
      r_outstanding <= r_outstanding + 3'd1;
    end else if (!w_ar_hs && w_r_done) begin
      r_outstanding <= r_outstanding - 3'd1;
    end
  end

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      r_state      <= IDLE;
      r_araddr     <= 32'd0;
      r_line_base  <= 32'd0;
      r_pitch      <= 32'd0;
      r_bpl        <= 16'd0;
      r_lines      <= 16'd0;
      r_burst      <= 16'd0;
      r_line       <= 16'd0;
      r_arvalid    <= 1'b0;
      r_abort      <= 1'b0;
      r_frame_done <= 1'b0;
      r_ovr        <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      if (!DISPON) begin
        r_ovr <= 1'b0;
      end else if (w_vr_rise && (r_state != IDLE)) begin
        r_ovr <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_vr_rise && DISPON) begin
            r_state     <= ISSUE;
            r_araddr    <= w_base;
            r_line_base <= w_base;
            r_pitch     <= w_pitch;
            r_bpl       <= w_geom.bpl;
            r_lines     <= w_geom.lines;
            r_burst     <= 16'd0;
            r_line      <= 16'd0;
            r_abort     <= 1'b0;
          end
        end

        ISSUE: begin
          // A raised ARVALID is committed: it waits for ARREADY whatever the pacing inputs do.
          if (r_arvalid) begin
            if (ARREADY) begin
              r_arvalid <= 1'b0;
              if (w_line_end) begin
                r_burst     <= 16'd0;
                r_line      <= r_line + 16'd1;
                r_line_base <= r_line_base + r_pitch;
                r_araddr    <= r_line_base + r_pitch;
                if (w_frame_end) begin
                  r_state <= DRAIN;
                end
              end else begin
                r_burst  <= r_burst + 16'd1;
                r_araddr <= r_araddr + BURST_BYTES_W;
              end
            end
          end else if (!DISPON) begin
            r_abort <= 1'b1;
            r_state <= DRAIN;
          end else if (BUF_WREADY && (r_outstanding < MAX_OUT_W)) begin
            r_arvalid <= 1'b1;
          end
        end

        DRAIN: begin
          if (r_outstanding == 3'd0) begin
            r_state      <= IDLE;
            r_frame_done <= !r_abort;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ARADDR      = r_araddr;
  assign ARLEN       = 8'(BURST_LEN - 1);
  assign ARSIZE      = 3'($clog2(DATA_W / 8));
  assign ARVALID     = r_arvalid;
  assign RREADY      = w_rready;
  assign BUSY        = (r_state != IDLE);
  assign FRAME_DONE  = r_frame_done;
  assign VRSTART_OVR = r_ovr;

endmodule

// File: tb/tb_disp_vramrd_engine.sv
// Directed self-checking bench for disp_vramrd_engine with default parameters.
`timescale 1ns/1ps
module tb_disp_vramrd_engine;

  logic        ACLK = 1'b0;
  logic        ARST;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic        ARVALID;
  logic        ARREADY;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic [1:0]  RESOL;
  logic        VRSTART;
  logic        DISPON;
  logic [28:0] DISPADDR;
  logic [15:0] STRIDE;
  logic        BUF_WREADY;
  logic        BUSY;
  logic        FRAME_DONE;
  logic        VRSTART_OVR;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ACLK = ~ACLK;

  disp_vramrd_engine dut (
    .ACLK        (ACLK),
    .ARST        (ARST),
    .ARADDR      (ARADDR),
    .ARLEN       (ARLEN),
    .ARSIZE      (ARSIZE),
    .ARVALID     (ARVALID),
    .ARREADY     (ARREADY),
    .RLAST       (RLAST),
    .RVALID      (RVALID),
    .RREADY      (RREADY),
    .RESOL       (RESOL),
    .VRSTART     (VRSTART),
    .DISPON      (DISPON),
    .DISPADDR    (DISPADDR),
`ifdef DISP_VRAMRD_STRIDE_EN
    .STRIDE      (STRIDE),
`endif
    .BUF_WREADY  (BUF_WREADY),
    .BUSY        (BUSY),
    .FRAME_DONE  (FRAME_DONE),
    .VRSTART_OVR (VRSTART_OVR)
  );

  // Bus monitor: sampled on the falling edge, inputs only move just after the rising edge.
  int          ar_cnt = 0;
  int          ar_base = 0;
  int          addr_err = 0, stab_err = 0, rr_err = 0, ovf_err = 0;
  int          fd_cnt = 0, fd_err = 0, rise_err = 0;
  int          mdl_out = 0;
  logic        prev_pend = 1'b0, prev_arv = 1'b0, prev_bufw = 1'b0, prev_don = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic [31:0] ar_log [0:63];
  logic [31:0] last_addr = 32'd0;
  logic [31:0] exp_base = 32'd0;
  int          exp_bpl = 20;
  logic [31:0] exp_pitch = 32'd2560;

  always @(negedge ACLK) begin
    int          k;
    logic [31:0] e;
    if (ARST) begin
      mdl_out   = 0;
      prev_pend = 1'b0;
      prev_arv  = 1'b0;
    end else begin
      if (ARVALID && ARREADY) begin
        k = ar_cnt - ar_base;
        e = exp_base + 32'(k / exp_bpl) * exp_pitch + 32'(k % exp_bpl) * 32'd128;
        if (ARADDR !== e) addr_err++;
        if (k < 64) ar_log[k] = ARADDR;
        last_addr = ARADDR;
        ar_cnt++;
      end
      if (prev_pend && (!ARVALID || ARADDR !== prev_addr)) stab_err++;
      if (!prev_arv && ARVALID && (!prev_bufw || !prev_don)) rise_err++;
      if (RREADY !== (mdl_out != 0)) rr_err++;
      mdl_out = mdl_out + ((ARVALID && ARREADY) ? 1 : 0) - ((RVALID && RREADY && RLAST) ? 1 : 0);
      if (mdl_out > 2) ovf_err++;
      if (FRAME_DONE) begin
        fd_cnt++;
        if (BUSY) fd_err++;
      end
      prev_pend = ARVALID && !ARREADY;
      prev_addr = ARADDR;
      prev_arv  = ARVALID;
    end
    prev_bufw = BUF_WREADY;
    prev_don  = DISPON;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic start_frame();
    VRSTART = 1'b1;
    tick(4);
    VRSTART = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget && to; i++) begin
      if (BUSY === 1'b0) to = 1'b0;
      else tick(1);
    end
    if (BUSY === 1'b0) to = 1'b0;
  endtask

  task automatic wait_ar(input int target, input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget && to; i++) begin
      if (ar_cnt - ar_base >= target) to = 1'b0;
      else tick(1);
    end
    if (ar_cnt - ar_base >= target) to = 1'b0;
  endtask

  task automatic set_frame(input logic [1:0] resol, input logic [28:0] dispaddr,
                           input logic [31:0] base, input int bpl, input logic [31:0] pitch);
    RESOL     = resol;
    DISPADDR  = dispaddr;
    STRIDE    = pitch[15:0];
    exp_base  = base;
    exp_bpl   = bpl;
    exp_pitch = pitch;
    ar_base   = ar_cnt;
  endtask

  task automatic test_reset();
    ARST = 1'b1; ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RESOL = 2'd0;
    VRSTART = 1'b0; DISPON = 1'b0; DISPADDR = 29'd0; STRIDE = 16'd0; BUF_WREADY = 1'b1;
    tick(3);
    if (ARVALID !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b want 0", ARVALID); end
    n_checks++;
    if (ARADDR !== 32'd0) begin n_fail++; $display("FAIL reset_araddr: got %h want 0", ARADDR); end
    n_checks++;
    if (ARLEN !== 8'd15) begin n_fail++; $display("FAIL reset_arlen: got %0d want 15", ARLEN); end
    n_checks++;
    if (ARSIZE !== 3'd3) begin n_fail++; $display("FAIL reset_arsize: got %0d want 3", ARSIZE); end
    n_checks++;
    if ({RREADY, BUSY, FRAME_DONE, VRSTART_OVR} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got rready/busy/done/ovr=%b want 0000", {RREADY, BUSY, FRAME_DONE, VRSTART_OVR});
    end
    n_checks++;
    ARST = 1'b0;
    tick(2);
  endtask

  task automatic test_start_gated();
    set_frame(2'd0, 29'd0, 32'd0, 20, 32'd2560);
    DISPON = 1'b0;
    start_frame();
    tick(10);
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL gated_busy: got %b want 0", BUSY); end
    n_checks++;
    if (ar_cnt - ar_base !== 0) begin n_fail++; $display("FAIL gated_ar: got %0d ARs want 0", ar_cnt - ar_base); end
    n_checks++;
    DISPON = 1'b1;
    tick(2);
  endtask

  task automatic test_frame_640();
    bit to;
    int fd0;
    set_frame(2'd0, 29'h0200_0000, 32'h1000_0000, 20, 32'd2560);
    ARREADY = 1'b1; RVALID = 1'b1; RLAST = 1'b1; BUF_WREADY = 1'b1;
    fd0 = fd_cnt;
    VRSTART = 1'b1;
    tick(2);
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL start_latency_early: BUSY=%b two cycles after edge, want 0", BUSY); end
    n_checks++;
    tick(1);
    if (BUSY !== 1'b1) begin n_fail++; $display("FAIL start_latency: BUSY=%b three cycles after edge, want 1", BUSY); end
    n_checks++;
    VRSTART = 1'b0;
    wait_idle(25000, to);
    if (to) begin n_fail++; $display("FAIL frame640_timeout: BUSY=%b want 0", BUSY); end
    n_checks++;
    tick(3);
    if (ar_cnt - ar_base !== 9600) begin n_fail++; $display("FAIL frame640_count: got %0d want 9600", ar_cnt - ar_base); end
    n_checks++;
    if (ar_log[0] !== 32'h1000_0000) begin n_fail++; $display("FAIL frame640_first: got %h want 10000000", ar_log[0]); end
    n_checks++;
    if (ar_log[20] !== 32'h1000_0A00) begin n_fail++; $display("FAIL frame640_line1: got %h want 10000a00", ar_log[20]); end
    n_checks++;
    if (last_addr !== 32'h1012_BF80) begin n_fail++; $display("FAIL frame640_last: got %h want 1012bf80", last_addr); end
    n_checks++;
    if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL frame640_done: got %0d pulses want 1", fd_cnt - fd0); end
    n_checks++;
    if (fd_err !== 0) begin n_fail++; $display("FAIL frame640_done_busy: %0d pulses with BUSY high, want 0", fd_err); end
    n_checks++;
    if (addr_err !== 0 || rr_err !== 0) begin
      n_fail++; $display("FAIL frame640_seq: addr_err=%0d rready_err=%0d want 0/0", addr_err, rr_err);
    end
    n_checks++;
  endtask

  task automatic test_ar_hold();
    bit          to;
    int          fd0;
    logic [31:0] a0;
    set_frame(2'd1, 29'h0000_001F, 32'h0000_0080, 25, 32'd3200);
    ARREADY = 1'b0;
    fd0 = fd_cnt;
    start_frame();
    to = 1'b1;
    for (int i = 0; i < 20 && to; i++) begin
      if (ARVALID === 1'b1) to = 1'b0;
      else tick(1);
    end
    if (to) begin n_fail++; $display("FAIL hold_arvalid_timeout: ARVALID=%b want 1", ARVALID); end
    n_checks++;
    a0 = ARADDR;
    BUF_WREADY = 1'b0;
    tick(5);
    if (ARVALID !== 1'b1 || ARADDR !== a0) begin
      n_fail++; $display("FAIL hold_stable: ARVALID=%b ARADDR=%h want 1/%h", ARVALID, ARADDR, a0);
    end
    n_checks++;
    if (a0 !== 32'h0000_0080) begin n_fail++; $display("FAIL hold_base_align: got %h want 00000080", a0); end
    n_checks++;
    BUF_WREADY = 1'b1;
    ARREADY = 1'b1;
    wait_idle(35000, to);
    if (to) begin n_fail++; $display("FAIL frame800_timeout: BUSY=%b want 0", BUSY); end
    n_checks++;
    tick(3);
    if (ar_cnt - ar_base !== 15000) begin n_fail++; $display("FAIL frame800_count: got %0d want 15000", ar_cnt - ar_base); end
    n_checks++;
    if (ar_log[24] !== 32'h0000_0C80 || ar_log[25] !== 32'h0000_0D00) begin
      n_fail++; $display("FAIL frame800_bpl: got %h/%h want 00000c80/00000d00", ar_log[24], ar_log[25]);
    end
    n_checks++;
    if (last_addr !== 32'h001D_4C00) begin n_fail++; $display("FAIL frame800_last: got %h want 001d4c00", last_addr); end
    n_checks++;
    if (fd_cnt - fd0 !== 1 || stab_err !== 0) begin
      n_fail++; $display("FAIL frame800_done: pulses=%0d stab_err=%0d want 1/0", fd_cnt - fd0, stab_err);
    end
    n_checks++;
  endtask

  task automatic test_outstanding();
    bit to;
    int fd0;
    set_frame(2'd0, 29'd0, 32'd0, 20, 32'd2560);
    ARREADY = 1'b1; RVALID = 1'b0; RLAST = 1'b0;
    fd0 = fd_cnt;
    start_frame();
    tick(20);
    if (ar_cnt - ar_base !== 2 || ARVALID !== 1'b0 || RREADY !== 1'b1) begin
      n_fail++; $display("FAIL outst_limit: ARs=%0d ARVALID=%b RREADY=%b want 2/0/1", ar_cnt - ar_base, ARVALID, RREADY);
    end
    n_checks++;
    ARREADY = 1'b0; RVALID = 1'b1; RLAST = 1'b0;
    tick(5);
    if (ar_cnt - ar_base !== 2 || ARVALID !== 1'b0) begin
      n_fail++; $display("FAIL outst_nonlast: ARs=%0d ARVALID=%b want 2/0", ar_cnt - ar_base, ARVALID);
    end
    n_checks++;
    RLAST = 1'b1;
    tick(1);
    RVALID = 1'b0; RLAST = 1'b0;
    tick(3);
    if (ARVALID !== 1'b1) begin n_fail++; $display("FAIL outst_resume: ARVALID=%b want 1", ARVALID); end
    n_checks++;
    ARREADY = 1'b1; RVALID = 1'b1; RLAST = 1'b1;
    tick(1);
    RVALID = 1'b0; RLAST = 1'b0;
    tick(20);
    if (ar_cnt - ar_base !== 4 || ARVALID !== 1'b0) begin
      n_fail++; $display("FAIL outst_simul: ARs=%0d ARVALID=%b want 4/0", ar_cnt - ar_base, ARVALID);
    end
    n_checks++;
    if (ovf_err !== 0 || rr_err !== 0 || addr_err !== 0) begin
      n_fail++; $display("FAIL outst_model: ovf=%0d rready_err=%0d addr_err=%0d want 0/0/0", ovf_err, rr_err, addr_err);
    end
    n_checks++;
    DISPON = 1'b0; RVALID = 1'b1; RLAST = 1'b1;
    wait_idle(50, to);
    tick(2);
    if (to || fd_cnt - fd0 !== 0) begin
      n_fail++; $display("FAIL outst_abort: timeout=%b pulses=%0d want 0/0", to, fd_cnt - fd0);
    end
    n_checks++;
    DISPON = 1'b1;
    tick(2);
  endtask

  task automatic test_bufw_stall();
    bit          to;
    int          n;
    logic [31:0] e;
    set_frame(2'd3, 29'h0000_0400, 32'h0000_2000, 20, 32'd2560);
    ARREADY = 1'b1; RVALID = 1'b1; RLAST = 1'b1; BUF_WREADY = 1'b1;
    start_frame();
    wait_ar(30, 200, to);
    BUF_WREADY = 1'b0;
    tick(2);
    n = ar_cnt - ar_base;
    tick(100);
    if (to || ar_cnt - ar_base !== n || ARVALID !== 1'b0) begin
      n_fail++; $display("FAIL stall_hold: ARs=%0d ARVALID=%b want %0d/0", ar_cnt - ar_base, ARVALID, n);
    end
    n_checks++;
    BUF_WREADY = 1'b1;
    wait_ar(n + 1, 20, to);
    e = 32'h0000_2000 + 32'(n / 20) * 32'd2560 + 32'(n % 20) * 32'd128;
    if (to || ar_log[n] !== e) begin
      n_fail++; $display("FAIL stall_resume_addr: got %h want %h (timeout=%b)", ar_log[n], e, to);
    end
    n_checks++;
    if (ar_log[20] !== 32'h0000_2A00) begin n_fail++; $display("FAIL resol3_line1: got %h want 00002a00", ar_log[20]); end
    n_checks++;
    if (rise_err !== 0) begin n_fail++; $display("FAIL stall_rise: %0d ARVALID rises while gated, want 0", rise_err); end
    n_checks++;
    DISPON = 1'b0;
    wait_idle(50, to);
    DISPON = 1'b1;
    tick(2);
  endtask

  task automatic test_abort_ovr();
    bit to;
    int fd0;
    set_frame(2'd2, 29'd0, 32'd0, 40, 32'd5120);
    ARREADY = 1'b1; RVALID = 1'b1; RLAST = 1'b1; BUF_WREADY = 1'b1;
    fd0 = fd_cnt;
    start_frame();
    wait_ar(50, 300, to);
    if (to) begin n_fail++; $display("FAIL abort_reach50: got %0d ARs want >=50", ar_cnt - ar_base); end
    n_checks++;
    start_frame();
    if (VRSTART_OVR !== 1'b1 || BUSY !== 1'b1) begin
      n_fail++; $display("FAIL ovr_set: OVR=%b BUSY=%b want 1/1", VRSTART_OVR, BUSY);
    end
    n_checks++;
    RVALID = 1'b0;
    tick(10);
    DISPON = 1'b0;
    tick(10);
    if (BUSY !== 1'b1 || RREADY !== 1'b1 || ARVALID !== 1'b0) begin
      n_fail++; $display("FAIL abort_drain: BUSY=%b RREADY=%b ARVALID=%b want 1/1/0", BUSY, RREADY, ARVALID);
    end
    n_checks++;
    if (VRSTART_OVR !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", VRSTART_OVR); end
    n_checks++;
    RVALID = 1'b1; RLAST = 1'b1;
    wait_idle(50, to);
    tick(2);
    if (to || fd_cnt - fd0 !== 0 || RREADY !== 1'b0) begin
      n_fail++; $display("FAIL abort_end: timeout=%b pulses=%0d RREADY=%b want 0/0/0", to, fd_cnt - fd0, RREADY);
    end
    n_checks++;
    if (addr_err !== 0 || rise_err !== 0) begin
      n_fail++; $display("FAIL abort_seq: addr_err=%0d rise_err=%0d want 0/0", addr_err, rise_err);
    end
    n_checks++;
    DISPON = 1'b1;
    tick(2);
  endtask

`ifdef DISP_VRAMRD_STRIDE_EN
  task automatic test_stride();
    bit to;
    set_frame(2'd0, 29'd0, 32'd0, 20, 32'h0000_1000);
    ARREADY = 1'b1; RVALID = 1'b1; RLAST = 1'b1;
    start_frame();
    wait_ar(45, 300, to);
    if (to || ar_log[20] !== 32'h0000_1000 || ar_log[40] !== 32'h0000_2000 || ar_log[41] !== 32'h0000_2080) begin
      n_fail++; $display("FAIL stride_lines: got %h/%h/%h want 00001000/00002000/00002080", ar_log[20], ar_log[40], ar_log[41]);
    end
    n_checks++;
    DISPON = 1'b0;
    wait_idle(50, to);
    DISPON = 1'b1;
    tick(2);
  endtask
`endif

  initial begin
    test_reset();
    test_start_gated();
    test_frame_640();
    test_ar_hold();
    test_outstanding();
    test_bufw_stall();
    test_abort_ovr();
`ifdef DISP_VRAMRD_STRIDE_EN
    test_stride();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
